// File: rtl/uart_transceiver_if.sv
// UART transceiver bundle: configuration, TX handshake, RX result and the
// two serial pins. The transceiver takes the slave side; the agent/DUT-side
// logic (or a testbench) takes the master side.
interface uart_transceiver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DIV_WIDTH  = 16
);
    logic [DIV_WIDTH-1:0]  baud_div;
    logic [1:0]            parity_mode;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx;
    logic                  rx;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_parity_err;
    logic                  rx_frame_err;

    modport master (
        output baud_div, parity_mode, tx_data, tx_valid, rx,
        input  tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );

    modport slave (
        input  baud_div, parity_mode, tx_data, tx_valid, rx,
        output tx_ready, tx, rx_data, rx_valid, rx_parity_err, rx_frame_err
    );
endinterface

// File: rtl/uart_transceiver.sv
// Full-duplex UART transceiver with run-time baud divisor.
// Optional feature macro: UART_PARITY_EN. When defined, parity generation and
// checking follow parity_mode; when undefined, frames never carry a parity bit
// and rx_parity_err stays 0.
//
// TX FSM
//   state     | meaning
//   TX_IDLE   | line high, tx_ready asserted
//   TX_START  | driving start bit (0)
//   TX_DATA   | driving data bits, LSB first
//   TX_PARITY | driving parity bit
//   TX_STOP   | driving STOP_BITS stop bits (1)
//
// RX FSM
//   state     | meaning
//   RX_IDLE   | waiting for synchronised low
//   RX_START  | waiting half a bit to confirm the start bit
//   RX_DATA   | sampling data bits at bit centres
//   RX_PARITY | sampling parity bit
//   RX_STOP   | sampling first stop bit, then publishing the word
//   RX_WAIT   | framing error seen, waiting for line to return high
module uart_transceiver #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    uart_transceiver_if.slave uart_io
);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_WIDTH);

    localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_HALF   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
    localparam logic PARITY_ON = 1'b1;
`else
    localparam logic PARITY_ON = 1'b0;
`endif

    localparam logic [2:0] TX_IDLE   = 3'd0;
    localparam logic [2:0] TX_START  = 3'd1;
    localparam logic [2:0] TX_DATA   = 3'd2;
    localparam logic [2:0] TX_PARITY = 3'd3;
    localparam logic [2:0] TX_STOP   = 3'd4;

    localparam logic [2:0] RX_IDLE   = 3'd0;
    localparam logic [2:0] RX_START  = 3'd1;
    localparam logic [2:0] RX_DATA   = 3'd2;
    localparam logic [2:0] RX_PARITY = 3'd3;
    localparam logic [2:0] RX_STOP   = 3'd4;
    localparam logic [2:0] RX_WAIT   = 3'd5;

    // parity_mode 11 is treated as "no parity"
    logic par_en_in;
    logic par_odd_in;
    assign par_en_in  = PARITY_ON && ((uart_io.parity_mode == 2'b01) || (uart_io.parity_mode == 2'b10));
    assign par_odd_in = (uart_io.parity_mode == 2'b10);

    // ---------------- transmitter ----------------
    logic [2:0]            tx_state_q,   tx_state_d;
    logic [DIV_WIDTH-1:0]  tx_div_q,     tx_div_d;
    logic [DIV_WIDTH-1:0]  tx_div_cnt_q, tx_div_cnt_d;
    logic [OS_W-1:0]       tx_os_cnt_q,  tx_os_cnt_d;
    logic [BIT_W-1:0]      tx_bit_cnt_q, tx_bit_cnt_d;
    logic [DATA_WIDTH-1:0] tx_shift_q,   tx_shift_d;
    logic                  tx_par_en_q,  tx_par_en_d;
    logic                  tx_par_bit_q, tx_par_bit_d;
    logic                  tx_q,         tx_d;
    logic                  tx_tick;
    logic                  tx_bit_end;

    // TX next-state: one bit period is OVERSAMPLE ticks of the private divider
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_div_d     = tx_div_q;
        tx_div_cnt_d = tx_div_cnt_q;
        tx_os_cnt_d  = tx_os_cnt_q;
        tx_bit_cnt_d = tx_bit_cnt_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_d         = tx_q;
        tx_tick      = (tx_div_cnt_q == tx_div_q);
        tx_bit_end   = tx_tick && (tx_os_cnt_q == OS_LAST);

        if (tx_state_q != TX_IDLE) begin
            tx_div_cnt_d = tx_tick ? '0 : tx_div_cnt_q + DIV_WIDTH'(1);
            if (tx_tick) begin
                tx_os_cnt_d = tx_bit_end ? '0 : tx_os_cnt_q + OS_W'(1);
            end
        end

        case (tx_state_q)
            TX_IDLE: begin
                if (uart_io.tx_valid) begin
                    tx_state_d   = TX_START;
                    tx_div_d     = uart_io.baud_div;
                    tx_div_cnt_d = '0;
                    tx_os_cnt_d  = '0;
                    tx_bit_cnt_d = '0;
                    tx_shift_d   = uart_io.tx_data;
                    tx_par_en_d  = par_en_in;
                    tx_par_bit_d = (^uart_io.tx_data) ^ par_odd_in;
                    tx_d         = 1'b0;
                end
            end
            TX_START: begin
                if (tx_bit_end) begin
                    tx_state_d = TX_DATA;
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
                end
            end
            TX_DATA: begin
                if (tx_bit_end) begin
                    if (tx_bit_cnt_q == DATA_LAST) begin
                        tx_bit_cnt_d = '0;
                        if (tx_par_en_q) begin
                            tx_state_d = TX_PARITY;
                            tx_d       = tx_par_bit_q;
                        end else begin
                            tx_state_d = TX_STOP;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + BIT_W'(1);
                        tx_d         = tx_shift_q[0];
                        tx_shift_d   = {1'b0, tx_shift_q[DATA_WIDTH-1:1]};
                    end
                end
            end
            TX_PARITY: begin
                if (tx_bit_end) begin
                    tx_state_d   = TX_STOP;
                    tx_bit_cnt_d = '0;
                    tx_d         = 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_bit_end) begin
                    if (tx_bit_cnt_q == STOP_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bit_cnt_d = tx_bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                tx_d       = 1'b1;
            end
        endcase
    end

    // TX registers; reset returns the line high immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q   <= TX_IDLE;
            tx_div_q     <= '0;
            tx_div_cnt_q <= '0;
            tx_os_cnt_q  <= '0;
            tx_bit_cnt_q <= '0;
            tx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            tx_q         <= 1'b1;
        end else begin
            tx_state_q   <= tx_state_d;
            tx_div_q     <= tx_div_d;
            tx_div_cnt_q <= tx_div_cnt_d;
            tx_os_cnt_q  <= tx_os_cnt_d;
            tx_bit_cnt_q <= tx_bit_cnt_d;
            tx_shift_q   <= tx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            tx_q         <= tx_d;
        end
    end

    assign uart_io.tx       = tx_q;
    assign uart_io.tx_ready = (tx_state_q == TX_IDLE);

    // ---------------- receiver ----------------
    logic                  rx_s1_q, rx_s2_q;
    logic                  rx_sync;
    logic [2:0]            rx_state_q,     rx_state_d;
    logic [DIV_WIDTH-1:0]  rx_div_q,       rx_div_d;
    logic [DIV_WIDTH-1:0]  rx_div_cnt_q,   rx_div_cnt_d;
    logic [OS_W-1:0]       rx_os_cnt_q,    rx_os_cnt_d;
    logic [BIT_W-1:0]      rx_bit_cnt_q,   rx_bit_cnt_d;
    logic [DATA_WIDTH-1:0] rx_shift_q,     rx_shift_d;
    logic                  rx_par_en_q,    rx_par_en_d;
    logic                  rx_par_odd_q,   rx_par_odd_d;
    logic                  rx_pend_perr_q, rx_pend_perr_d;
    logic [DATA_WIDTH-1:0] rx_data_q,      rx_data_d;
    logic                  rx_valid_q,     rx_valid_d;
    logic                  rx_perr_q,      rx_perr_d;
    logic                  rx_ferr_q,      rx_ferr_d;
    logic                  rx_tick;
    logic                  rx_sample;

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= uart_io.rx;
            rx_s2_q <= rx_s1_q;
        end
    end

    assign rx_sync = rx_s2_q;

    // RX next-state: first sample at half a bit, then every full bit period
    always_comb begin
        rx_state_d     = rx_state_q;
        rx_div_d       = rx_div_q;
        rx_div_cnt_d   = rx_div_cnt_q;
        rx_os_cnt_d    = rx_os_cnt_q;
        rx_bit_cnt_d   = rx_bit_cnt_q;
        rx_shift_d     = rx_shift_q;
        rx_par_en_d    = rx_par_en_q;
        rx_par_odd_d   = rx_par_odd_q;
        rx_pend_perr_d = rx_pend_perr_q;
        rx_data_d      = rx_data_q;
        rx_valid_d     = 1'b0;
        rx_perr_d      = rx_perr_q;
        rx_ferr_d      = rx_ferr_q;
        rx_tick        = (rx_div_cnt_q == rx_div_q);
        rx_sample      = rx_tick &&
                         (rx_os_cnt_q == ((rx_state_q == RX_START) ? OS_HALF : OS_LAST));

        if ((rx_state_q != RX_IDLE) && (rx_state_q != RX_WAIT)) begin
            rx_div_cnt_d = rx_tick ? '0 : rx_div_cnt_q + DIV_WIDTH'(1);
            if (rx_tick) begin
                rx_os_cnt_d = rx_sample ? '0 : rx_os_cnt_q + OS_W'(1);
            end
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_state_d     = RX_START;
                    rx_div_d       = uart_io.baud_div;
                    rx_div_cnt_d   = '0;
                    rx_os_cnt_d    = '0;
                    rx_bit_cnt_d   = '0;
                    rx_par_en_d    = par_en_in;
                    rx_par_odd_d   = par_odd_in;
                    rx_pend_perr_d = 1'b0;
                end
            end
            RX_START: begin
                if (rx_sample) begin
                    rx_state_d = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_sample) begin
                    rx_shift_d = {rx_sync, rx_shift_q[DATA_WIDTH-1:1]};
                    if (rx_bit_cnt_q == DATA_LAST) begin
                        rx_bit_cnt_d = '0;
                        rx_state_d   = rx_par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bit_cnt_d = rx_bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            RX_PARITY: begin
                if (rx_sample) begin
                    rx_pend_perr_d = ((^rx_shift_q) ^ rx_sync) != rx_par_odd_q;
                    rx_state_d     = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_sample) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_perr_d  = PARITY_ON && rx_pend_perr_q;
                    rx_ferr_d  = !rx_sync;
                    rx_state_d = rx_sync ? RX_IDLE : RX_WAIT;
                end
            end
            RX_WAIT: begin
                if (rx_sync) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX registers; outputs only change on the rx_valid cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state_q     <= RX_IDLE;
            rx_div_q       <= '0;
            rx_div_cnt_q   <= '0;
            rx_os_cnt_q    <= '0;
            rx_bit_cnt_q   <= '0;
            rx_shift_q     <= '0;
            rx_par_en_q    <= 1'b0;
            rx_par_odd_q   <= 1'b0;
            rx_pend_perr_q <= 1'b0;
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_perr_q      <= 1'b0;
            rx_ferr_q      <= 1'b0;
        end else begin
            rx_state_q     <= rx_state_d;
            rx_div_q       <= rx_div_d;
            rx_div_cnt_q   <= rx_div_cnt_d;
            rx_os_cnt_q    <= rx_os_cnt_d;
            rx_bit_cnt_q   <= rx_bit_cnt_d;
            rx_shift_q     <= rx_shift_d;
            rx_par_en_q    <= rx_par_en_d;
            rx_par_odd_q   <= rx_par_odd_d;
            rx_pend_perr_q <= rx_pend_perr_d;
            rx_data_q      <= rx_data_d;
            rx_valid_q     <= rx_valid_d;
            rx_perr_q      <= rx_perr_d;
            rx_ferr_q      <= rx_ferr_d;
        end
    end

    assign uart_io.rx_data       = rx_data_q;
    assign uart_io.rx_valid      = rx_valid_q;
    assign uart_io.rx_parity_err = PARITY_ON ? rx_perr_q : 1'b0;
    assign uart_io.rx_frame_err  = rx_ferr_q;
endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Parametrised full-duplex UART transceiver that drives and samples the `tx`/`rx` pins carried by the UART pin interface. It serialises parallel words under a valid/ready handshake and deserialises received frames with parity and framing checks. It uses a run-time baud divisor and compile-time word width, oversampling and stop-bit count. It sits between the pin interface and the agent/DUT-side logic in the hdlTop.

## Interface
- `DATA_WIDTH`, 8, data bits per frame (5..9).
- `OVERSAMPLE`, 16, ticks per bit period (even, ≥4).
- `DIV_WIDTH`, 16, width of `baud_div`.
- `STOP_BITS`, 1, stop bits transmitted (1 or 2).

- `clk`  in  1  single clock for all logic.
- `reset`  in  1  asynchronous, active-high reset.
- `baud_div`  in  DIV_WIDTH  clocks per tick minus 1; bit period = OVERSAMPLE*(baud_div+1) clocks.
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- `tx_data`  in  DATA_WIDTH  word to send.
- `tx_valid`  in  1  `tx_data` valid.
- `tx_ready`  out  1  transmitter idle and able to accept.
- `tx`  out  1  serial output, idle high.
- `rx`  in  1  serial input, asynchronous to `clk`.
- `rx_data`  out  DATA_WIDTH  last received word.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` and error flags updated.
- `rx_parity_err`  out  1  parity mismatch on last frame.
- `rx_frame_err`  out  1  first stop bit sampled low on last frame.

## Operation
- Frame: start (0), DATA_WIDTH bits LSB first, optional parity bit, stop bits (1). Even parity: XOR of data bits plus parity bit is 0. Odd parity: that XOR is 1.
- TX and RX each have a private tick divider that counts 0..baud_div. Each divider restarts at its own frame start, so bit periods are exact. `baud_div` and `parity_mode` are sampled at frame start and held for the whole frame.
- TX FSM states: IDLE → START → DATA → PARITY (skipped if no parity) → STOP → IDLE.
  - Acceptance occurs when `tx_valid && tx_ready`. The data is captured and `tx_ready` deasserts the next cycle.
  - Each state lasts OVERSAMPLE ticks per bit. STOP lasts STOP_BITS bits.
- RX: `rx` passes through a 2-flop synchroniser reset to 1.
  - RX FSM states: IDLE → START → DATA → PARITY (if enabled) → STOP → (WAIT_IDLE) → IDLE.
  - IDLE: a synchronised low starts the frame.
  - START: after OVERSAMPLE/2 ticks the line is resampled. If it is high, the start was false: return to IDLE with no output.
  - DATA, PARITY and STOP are each sampled at the bit centre, every OVERSAMPLE ticks after the start-bit centre. Only the first stop bit is checked.
- RX uses no buffer. Each frame overwrites `rx_data`. The consumer must capture it on `rx_valid`.
- Frame error (stop sampled low): enter WAIT_IDLE and remain until the synchronised `rx` is high. A break condition therefore yields exactly one frame.

## Timing
- Reset values: `tx`=1, `tx_ready`=1, `rx_valid`=0, `rx_data`=0, `rx_parity_err`=0, `rx_frame_err`=0. All FSMs go to IDLE and the dividers clear.
- TX: `tx` falls on the cycle after acceptance.
  - Frame length = (1+DATA_WIDTH+P+STOP_BITS)*OVERSAMPLE*(baud_div+1) clocks, where P=1 if parity is enabled, else 0.
  - `tx_ready` rises on the first cycle after the last stop-bit period. Back-to-back acceptance is allowed in that cycle, giving no idle gap.
- RX: `rx_valid` pulses one clock after the stop-bit centre sample. Data and flags change only in that cycle and hold until the next `rx_valid`.
- Latency from `rx` falling edge to `rx_valid` is approximately (DATA_WIDTH+P+1.5)*OVERSAMPLE*(baud_div+1)+3 clocks. The +3 covers the synchroniser and the output register.
- `baud_div`=0 is legal: one tick per clock.
- Asserting `reset` mid-frame aborts both directions immediately. `tx` returns high asynchronously and no `rx_valid` is produced for the partial frame.

## Configuration
- `UART_PARITY_EN` defined: parity generation and checking are compiled in and `parity_mode` is honoured.
- `UART_PARITY_EN` undefined: the PARITY states are removed, `parity_mode` is ignored, P=0 always, and `rx_parity_err` is tied 0.

## Test plan
- Reset: assert `reset` mid TX frame → `tx`=1 and `tx_ready`=1 immediately. No `rx_valid` after deassert.
- TX 8N1, `baud_div`=0, OVERSAMPLE=16, send 0xA5 → `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks. `tx_ready` high again after 160 clocks.
- Loopback `tx`→`rx`, even parity, send 0x3C then odd parity send 0x3C → `rx_data`=0x3C both times, `rx_parity_err`=0. Parity bit sent as 0 then 1.
- Drive a frame with the wrong parity bit (even mode, 0x01, parity 0) → `rx_valid` pulse, `rx_data`=0x01, `rx_parity_err`=1.
- Hold `rx` low for 3 frame times (break) → exactly one `rx_valid`, `rx_data`=0, `rx_frame_err`=1. The next good frame 0x55 gives `rx_frame_err`=0.
- 4-clock low glitch on `rx` with `baud_div`=3 → no `rx_valid`, and the RX FSM returns to IDLE.
